vram_port_arbiter: RTL and testbench

- Shares the single CPU-side port of one VRAM (VRAM32, VRAM8 or VRAMSPR) between two requesters: port 0 is the MemoryUnit and port 1 is a blitter/DMA engine.
- Grants at most one access per clk cycle, using fixed priority to port 0 with an anti-starvation counter for port 1.
- Returns read data to the correct requester through a tagged two-stage pipeline.
- Sits between the requesters and the VRAM cpu_* pins; the GPU side is untouched.

---
 rtl/vram_port_arbiter_pkg.sv | 24 ++
 rtl/vram_port_arbiter_if.sv | 16 +
 rtl/vram_port_arbiter_read_pipe.sv | 58 +++++
 rtl/vram_port_arbiter.sv | 93 +++++++++
 tb/tb_vram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_port_arbiter_pkg.sv
// Shared constants, read-tag type and width helper for vram_port_arbiter.
package vram_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_BLT = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } read_tag_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// One requester-side VRAM access port: request/attributes in, grant and read data out.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    logic              gnt;
    logic [DATA_W-1:0] q;
    logic              qvalid;

    modport master (output req, we, addr, d, input gnt, q, qvalid);
    modport slave  (input req, we, addr, d, output gnt, q, qvalid);
endinterface

// File: rtl/vram_port_arbiter_read_pipe.sv
// Tagged two-stage read return: tag at grant edge, capture vram_q one cycle
// later, qvalid pulse on the owning port the cycle after that.
module vram_read_pipe
    import vram_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_grant,
    input  logic              i_rd_port,
    input  logic [DATA_W-1:0] i_vram_q,
    output logic [DATA_W-1:0] o_p0_q,
    output logic [DATA_W-1:0] o_p1_q,
    output logic              o_p0_qvalid,
    output logic              o_p1_qvalid
);

    read_tag_t         r_tag;
    logic [DATA_W-1:0] r_p0_q;
    logic [DATA_W-1:0] r_p1_q;
    logic              r_p0_qvalid;
    logic              r_p1_qvalid;
    logic              w_cap_p0;
    logic              w_cap_p1;

    assign w_cap_p0 = r_tag.valid && (r_tag.port == PORT_CPU);
    assign w_cap_p1 = r_tag.valid && (r_tag.port == PORT_BLT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag       <= '0;
            r_p0_q      <= '0;
            r_p1_q      <= '0;
            r_p0_qvalid <= 1'b0;
            r_p1_qvalid <= 1'b0;
        end else begin
            r_tag.valid <= i_rd_grant;
            r_tag.port  <= i_rd_port;
            r_p0_qvalid <= w_cap_p0;
            r_p1_qvalid <= w_cap_p1;
            if (w_cap_p0) begin
                r_p0_q <= i_vram_q;
            end
            if (w_cap_p1) begin
                r_p1_q <= i_vram_q;
            end
        end
    end

    assign o_p0_q      = r_p0_q;
    assign o_p1_q      = r_p1_q;
    assign o_p0_qvalid = r_p0_qvalid;
    assign o_p1_qvalid = r_p1_qvalid;

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for one VRAM CPU port. Fixed priority to port 0 with
// anti-starvation for port 1; define VRAM_ARB_RR_EN for strict round-robin.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vram_port_arbiter_if.slave   p0,
    vram_port_arbiter_if.slave   p1,
    output logic [ADDR_W-1:0]    vram_addr,
    output logic [DATA_W-1:0]    vram_d,
    output logic                 vram_we,
    input  logic [DATA_W-1:0]    vram_q
);

    logic w_win0;
    logic w_win1;
    logic w_p1_prio;
    logic w_rd_grant;

`ifdef VRAM_ARB_RR_EN
    logic r_last_win;

    // Reset value favours port 0 for the first contended grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_win <= PORT_BLT;
        end else if (w_win0 || w_win1) begin
            r_last_win <= w_win1;
        end
    end

    assign w_p1_prio = (r_last_win == PORT_CPU);
`else
    localparam int              WAIT_W   = clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;

    // Counts consecutive cycles port 1 asked and lost; saturates at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!p1.req || w_win1) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_p1_prio = (r_wait_cnt == WAIT_MAX);
`endif

    always_comb begin
        // NOTE: defaults first so that no branch leaves a signal unassigned
        // and infers a latch.
        w_win0 = 1'b0;
        w_win1 = 1'b0;
        if (!reset) begin
            w_win1 = p1.req && (!p0.req || w_p1_prio);
            w_win0 = p0.req && !w_win1;
        end
    end

    assign p0.gnt = w_win0;
    assign p1.gnt = w_win1;

    // Idle cycles present port 0's attributes; harmless since vram_we is low.
    assign vram_addr = w_win1 ? p1.addr : p0.addr;
    assign vram_d    = w_win1 ? p1.d    : p0.d;
    assign vram_we   = (w_win0 && p0.we) || (w_win1 && p1.we);

    assign w_rd_grant = (w_win0 && !p0.we) || (w_win1 && !p1.we);

    vram_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk         (clk),
        .reset       (reset),
        .i_rd_grant  (w_rd_grant),
        .i_rd_port   (w_win1),
        .i_vram_q    (vram_q),
        .o_p0_q      (p0.q),
        .o_p1_q      (p1.q),
        .o_p0_qvalid (p0.qvalid),
        .o_p1_qvalid (p1.qvalid)
    );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios plus random
// traffic against a transaction-level model (grant rule, shadow memory, return queues).
module tb_vram_port_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_d;
    logic              vram_we;
    logic [DATA_W-1:0] vram_q;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();

    vram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p0        (p0_if),
        .p1        (p1_if),
        .vram_addr (vram_addr),
        .vram_d    (vram_d),
        .vram_we   (vram_we),
        .vram_q    (vram_q)
    );

    always #5 clk = ~clk;

    // Synchronous read-first VRAM: q is valid the cycle after the address edge.
    logic [DATA_W-1:0] vram_mem [DEPTH];
    always @(posedge clk) begin
        vram_q <= vram_mem[vram_addr];
        if (vram_we) vram_mem[vram_addr] = vram_d;
    end

    // Reference model state.
    typedef struct {
        int                cyc_due;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic [DATA_W-1:0] shadow [DEPTH];
    rd_t               pend0[$];
    rd_t               pend1[$];
    logic [DATA_W-1:0] exp_q0, exp_q1;
    int                lost;
    int                last_win;
    int                cyc;
    int                n_checks;
    int                n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic set_p0(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] d);
        p0_if.req = req; p0_if.we = we; p0_if.addr = ADDR_W'(addr); p0_if.d = d;
    endtask

    task automatic set_p1(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] d);
        p1_if.req = req; p1_if.we = we; p1_if.addr = ADDR_W'(addr); p1_if.d = d;
    endtask

    // One clock cycle: check the DUT against the model mid-cycle, then advance the model.
    task automatic step(output logic g0, output logic g1);
        logic e0, e1, ev0, ev1;
        rd_t  r;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!reset) begin
`ifdef VRAM_ARB_RR_EN
            e1 = p1_if.req && (!p0_if.req || last_win == 0);
`else
            e1 = p1_if.req && (!p0_if.req || lost >= MAX_WAIT);
`endif
            e0 = p0_if.req && !e1;
        end
        ev0 = (pend0.size() > 0) && (pend0[0].cyc_due == cyc);
        ev1 = (pend1.size() > 0) && (pend1[0].cyc_due == cyc);
        if (ev0) begin r = pend0.pop_front(); exp_q0 = r.data; end
        if (ev1) begin r = pend1.pop_front(); exp_q1 = r.data; end

        check("p0_gnt", 64'(p0_if.gnt), 64'(e0));
        check("p1_gnt", 64'(p1_if.gnt), 64'(e1));
        check("vram_we", 64'(vram_we), 64'((e0 && p0_if.we) || (e1 && p1_if.we)));
        check("vram_addr", 64'(vram_addr), 64'(e1 ? p1_if.addr : p0_if.addr));
        if (vram_we) check("vram_d", 64'(vram_d), 64'(e1 ? p1_if.d : p0_if.d));
        check("p0_qvalid", 64'(p0_if.qvalid), 64'(ev0));
        check("p1_qvalid", 64'(p1_if.qvalid), 64'(ev1));
        check("p0_q", 64'(p0_if.q), 64'(exp_q0));
        check("p1_q", 64'(p1_if.q), 64'(exp_q1));

        if (reset) begin
            lost = 0;
            last_win = 1;
            pend0.delete();
            pend1.delete();
            exp_q0 = '0;
            exp_q1 = '0;
        end else begin
            if (e0) begin
                if (p0_if.we) shadow[p0_if.addr] = p0_if.d;
                else pend0.push_back('{cyc + 2, shadow[p0_if.addr]});
                last_win = 0;
            end
            if (e1) begin
                if (p1_if.we) shadow[p1_if.addr] = p1_if.d;
                else pend1.push_back('{cyc + 2, shadow[p1_if.addr]});
                last_win = 1;
            end
            if (p1_if.req && !e1) lost = (lost < MAX_WAIT) ? lost + 1 : MAX_WAIT;
            else lost = 0;
        end
        g0 = e0;
        g1 = e1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic g0, g1;
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] alt_data [4];
        int   pat [10];
        logic p0_pend, p1_pend;

        n_checks = 0; n_fail = 0; cyc = 0; lost = 0; last_win = 1;
        exp_q0 = '0; exp_q1 = '0;
        reset = 1'b1;
        set_p0(1'b0, 1'b0, 0, '0);
        set_p1(1'b0, 1'b0, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            vram_mem[i] = v;
            shadow[i] = v;
        end
        vram_mem[14'h010] = 32'hDEADBEEF; shadow[14'h010] = 32'hDEADBEEF;
        alt_data[0] = 32'hA0A0_0001; alt_data[1] = 32'hB1B1_0002;
        alt_data[2] = 32'hC2C2_0003; alt_data[3] = 32'hD3D3_0004;
        for (int i = 0; i < 4; i++) begin
            vram_mem[14'h030 + i] = alt_data[i];
            shadow[14'h030 + i] = alt_data[i];
        end

        // Reset with a write pending on p0: no grant, no write strobe.
        set_p0(1'b1, 1'b1, 14'h010, 32'h0BAD_0BAD);
        step(g0, g1);
        step(g0, g1);
        set_p0(1'b0, 1'b0, 0, '0);
        reset = 1'b0;
        check("rst_p0_q", 64'(p0_if.q), 64'h0);
        check("rst_p1_qvalid", 64'(p1_if.qvalid), 64'h0);

        // Single read of 0x010 on port 0.
        set_p0(1'b1, 1'b0, 14'h010, '0);
        step(g0, g1);
        check("single_gnt", 64'(g0), 64'h1);
        set_p0(1'b0, 1'b0, 0, '0);
        step(g0, g1);
        check("single_qvalid", 64'(p0_if.qvalid), 64'h1);
        check("single_q", 64'(p0_if.q), 64'hDEADBEEF);
        check("single_p1_qvalid", 64'(p1_if.qvalid), 64'h0);
        step(g0, g1);

        // Contention from a fresh reset: both ports read continuously.
        reset = 1'b1;
        step(g0, g1);
        reset = 1'b0;
`ifdef VRAM_ARB_RR_EN
        pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        for (int k = 0; k < 10; k++) begin
            set_p0(1'b1, 1'b0, 14'h040 + k, '0);
            set_p1(1'b1, 1'b0, 14'h050 + k, '0);
            #1;
            check("cont_p1_gnt", 64'(p1_if.gnt), 64'(pat[k]));
            step(g0, g1);
        end
        set_p0(1'b0, 1'b0, 0, '0);
        set_p1(1'b0, 1'b0, 0, '0);
        step(g0, g1);
        step(g0, g1);

        // Write on p1 then read-back on p0 in the next cycle.
        set_p1(1'b1, 1'b1, 14'h020, 32'h12345678);
        step(g0, g1);
        set_p1(1'b0, 1'b0, 0, '0);
        set_p0(1'b1, 1'b0, 14'h020, '0);
        step(g0, g1);
        set_p0(1'b0, 1'b0, 0, '0);
        step(g0, g1);
        check("wr_rd_qvalid", 64'(p0_if.qvalid), 64'h1);
        check("wr_rd_q", 64'(p0_if.q), 64'h12345678);
        step(g0, g1);

        // Alternating single-port reads 0,1,0,1 with distinct data.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) set_p0(1'b1, 1'b0, 14'h030 + k, '0);
            else set_p1(1'b1, 1'b0, 14'h030 + k, '0);
            step(g0, g1);
            set_p0(1'b0, 1'b0, 0, '0);
            set_p1(1'b0, 1'b0, 0, '0);
        end
        step(g0, g1);
        step(g0, g1);
        check("alt_p0_q", 64'(p0_if.q), 64'(alt_data[2]));
        check("alt_p1_q", 64'(p1_if.q), 64'(alt_data[3]));

        // Reset one cycle after a p1 read grant: the read must vanish.
        set_p1(1'b1, 1'b0, 14'h031, '0);
        step(g0, g1);
        set_p1(1'b0, 1'b0, 0, '0);
        reset = 1'b1;
        step(g0, g1);
        reset = 1'b0;
        check("mid_rst_p1_qvalid", 64'(p1_if.qvalid), 64'h0);
        check("mid_rst_p1_q", 64'(p1_if.q), 64'h0);
        check("mid_rst_p0_q", 64'(p0_if.q), 64'h0);
        step(g0, g1);
        step(g0, g1);

        // Random traffic honouring the hold-until-grant handshake.
        p0_pend = 1'b0;
        p1_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0_pend || $urandom_range(0, 15) == 0) begin
                set_p0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, 31)), $urandom);
            end
            if (!p1_pend || $urandom_range(0, 15) == 0) begin
                set_p1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, 31)), $urandom);
            end
            reset = (i == 200);
            step(g0, g1);
            p0_pend = p0_if.req && !g0;
            p1_pend = p1_if.req && !g1;
        end
        reset = 1'b0;
        set_p0(1'b0, 1'b0, 0, '0);
        set_p1(1'b0, 1'b0, 0, '0);
        step(g0, g1);
        step(g0, g1);
        step(g0, g1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
